contador_cm_param: RTL and testbench

Parametrised successor of the single-digit-pair cm measurement control.
- Integrates the tick prescaler and an N-digit BCD cm counter behind one FSM.
- Adds a saturation/timeout limit, a registered result with a one-cycle `pronto` strobe, and an optional rounding mode.
- Sits between the echo-pulse synchroniser and the distance display/serial formatter.

---
 rtl/contador_cm_param_if.sv | 22 ++
 rtl/contador_cm_param.sv | 176 +++++++++++++++++
 tb/tb_contador_cm_param.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/contador_cm_param_if.sv
// Bundle between the echo synchroniser, the cm measurement block and the display/serial side.
// The measurement block uses the slave view; the consumer/stimulus side uses the master view.
interface contador_cm_param_if #(
  parameter int DIGITOS = 3
);
  logic                   pulso;
  logic [4*DIGITOS-1:0]   medida;
  logic                   pronto;
  logic                   timeout;
  logic                   ocupado;
  logic [2:0]             db_estado;

  modport master (
    output pulso,
    input  medida, pronto, timeout, ocupado, db_estado
  );

  modport slave (
    input  pulso,
    output medida, pronto, timeout, ocupado, db_estado
  );
endinterface

// File: rtl/contador_cm_param.sv
// Echo-pulse to BCD centimetre converter: tick prescaler, N-digit BCD counter, saturation at MAX_CM.
// Optional macro ARREDONDA_EN: round the result to nearest cm instead of truncating.
module contador_cm_param #(
  parameter int TICKS_POR_CM = 2941,
  parameter int DIGITOS      = 3,
  parameter int MAX_CM       = 400
) (
  input  logic clock,
  input  logic reset,
  contador_cm_param_if.slave bus
);

  localparam int TW = $clog2(TICKS_POR_CM);
  localparam int BW = 4 * DIGITOS;

  typedef enum logic [2:0] {
    INICIAL    = 3'b000,
    PREPARACAO = 3'b001,
    MEDINDO    = 3'b010,
    FIM        = 3'b011,
    TIMEOUT    = 3'b100
  } estado_t;

  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < DIGITOS; d++) begin
      if (carry) begin
        if (v[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
          carry       = 1'b1;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        carry = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] to_bcd(input int n);
    logic [BW-1:0] r;
    int            rem;
    r   = '0;
    rem = n;
    for (int d = 0; d < DIGITOS; d++) begin
      r[4*d +: 4] = 4'(rem % 10);
      rem         = rem / 10;
    end
    return r;
  endfunction

  localparam logic [BW-1:0] MAX_BCD  = to_bcd(MAX_CM);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_POR_CM - 1);

  estado_t         r_estado;
  logic [TW-1:0]   r_tick;
  logic [BW-1:0]   r_bcd;
  logic [BW-1:0]   r_medida;
  logic            r_pronto;
  logic            r_timeout;
  logic            r_ocupado;
  logic [BW-1:0]   w_bcd_inc;
  logic [BW-1:0]   w_resultado;

  assign w_bcd_inc = bcd_inc(r_bcd);

`ifdef ARREDONDA_EN
  localparam logic [TW-1:0] TICK_HALF = TW'(TICKS_POR_CM / 2);

  // Count never exceeds MAX_CM-1 here, but the clamp keeps the result bounded regardless.
  always_comb begin
    w_resultado = r_bcd;
    if (r_tick >= TICK_HALF) begin
      if (w_bcd_inc > MAX_BCD) begin
        w_resultado = MAX_BCD;
      end else begin
        w_resultado = w_bcd_inc;
      end
    end else begin
      w_resultado = r_bcd;
    end
  end
`else
  assign w_resultado = r_bcd;
`endif

  // Measurement FSM; every output is registered and takes its value alongside the state it belongs to.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado  <= INICIAL;
      r_tick    <= '0;
      r_bcd     <= '0;
      r_medida  <= '0;
      r_pronto  <= 1'b0;
      r_timeout <= 1'b0;
      r_ocupado <= 1'b0;
    end else begin
      r_pronto <= 1'b0;
      case (r_estado)
        INICIAL: begin
          r_estado  <= PREPARACAO;
          r_ocupado <= 1'b0;
        end
        PREPARACAO: begin
          r_bcd <= '0;
          if (bus.pulso) begin
            r_tick    <= TW'(1);
            r_estado  <= MEDINDO;
            r_ocupado <= 1'b1;
          end else begin
            r_tick    <= '0;
            r_estado  <= PREPARACAO;
            r_ocupado <= 1'b0;
          end
        end
        MEDINDO: begin
          if (bus.pulso) begin
            if (r_tick == TICK_MAX) begin
              r_tick <= '0;
              r_bcd  <= w_bcd_inc;
              if (w_bcd_inc == MAX_BCD) begin
                r_estado  <= TIMEOUT;
                r_medida  <= MAX_BCD;
                r_pronto  <= 1'b1;
                r_timeout <= 1'b1;
                r_ocupado <= 1'b0;
              end else begin
                r_estado  <= MEDINDO;
                r_ocupado <= 1'b1;
              end
            end else begin
              r_tick    <= r_tick + TW'(1);
              r_estado  <= MEDINDO;
              r_ocupado <= 1'b1;
            end
          end else begin
            // Falling edge wins over a coincident wrap: the final cycle is not counted.
            r_estado  <= FIM;
            r_medida  <= w_resultado;
            r_pronto  <= 1'b1;
            r_timeout <= 1'b0;
            r_ocupado <= 1'b0;
          end
        end
        FIM: begin
          r_estado  <= PREPARACAO;
          r_ocupado <= 1'b0;
        end
        TIMEOUT: begin
          r_ocupado <= 1'b0;
          if (bus.pulso) begin
            r_estado <= TIMEOUT;
          end else begin
            r_estado <= PREPARACAO;
          end
        end
        default: begin
          r_estado  <= INICIAL;
          r_ocupado <= 1'b0;
        end
      endcase
    end
  end

  assign bus.medida    = r_medida;
  assign bus.pronto    = r_pronto;
  assign bus.timeout   = r_timeout;
  assign bus.ocupado   = r_ocupado;
  assign bus.db_estado = r_estado;

endmodule

// File: tb/tb_contador_cm_param.sv
// Directed, table-driven bench for contador_cm_param (small instance 4/3/20 plus a full-scale 2941/3/400 one).
// Expectations switch to rounded values when ARREDONDA_EN is defined.
module tb_contador_cm_param;

`ifdef ARREDONDA_EN
  localparam bit ARR = 1'b1;
`else
  localparam bit ARR = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  contador_cm_param_if #(.DIGITOS(3)) ifa ();
  contador_cm_param_if #(.DIGITOS(3)) ifb ();

  contador_cm_param #(.TICKS_POR_CM(4), .DIGITOS(3), .MAX_CM(20)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (ifa)
  );

  contador_cm_param #(.TICKS_POR_CM(2941), .DIGITOS(3), .MAX_CM(400)) dut_big (
    .clock (clk),
    .reset (rst_n),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [11:0] med;
    logic        tmo;
    int          pronto_at;
    int          ocup;
    logic [2:0]  est_n;
  } vec_t;

  vec_t tab[10];

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nome, got, exp);
    end
  endtask

  // Drive a pulse of n high samples starting from PREPARACAO and watch the outputs for n+6 cycles.
  task automatic measure(input bit big, input int n, output int npronto, output int pronto_at,
                         output logic [11:0] med_p, output logic tmo_p, output int ocup,
                         output logic [2:0] est_n);
    npronto   = 0;
    pronto_at = -1;
    med_p     = 12'hfff;
    tmo_p     = 1'bx;
    ocup      = 0;
    est_n     = 3'bxxx;
    if (big) ifb.pulso = 1'b1; else ifa.pulso = 1'b1;
    for (int c = 1; c <= n + 6; c++) begin
      @(posedge clk); #1;
      if (c == n) begin
        if (big) ifb.pulso = 1'b0; else ifa.pulso = 1'b0;
        est_n = big ? ifb.db_estado : ifa.db_estado;
      end
      if (big ? ifb.pronto : ifa.pronto) begin
        npronto++;
        pronto_at = c;
        med_p     = big ? ifb.medida : ifa.medida;
        tmo_p     = big ? ifb.timeout : ifa.timeout;
      end
      if (big ? ifb.ocupado : ifa.ocupado) ocup++;
    end
  endtask

  initial begin
    int          np, pat, oc;
    logic [11:0] mp;
    logic        tp;
    logic [2:0]  es;

    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    ifa.pulso = 1'b0;
    ifb.pulso = 1'b0;

    tab[0] = '{10,  ARR ? 12'h003 : 12'h002, 1'b0, 11,  10, 3'b010};
    tab[1] = '{48,  12'h012,                 1'b0, 49,  48, 3'b010};
    tab[2] = '{3,   ARR ? 12'h001 : 12'h000, 1'b0, 4,   3,  3'b010};
    tab[3] = '{100, 12'h020,                 1'b1, 80,  79, 3'b100};
    tab[4] = '{8,   12'h002,                 1'b0, 9,   8,  3'b010};
    tab[5] = '{1,   12'h000,                 1'b0, 2,   1,  3'b010};
    tab[6] = '{79,  ARR ? 12'h020 : 12'h019, 1'b0, 80,  79, 3'b010};
    tab[7] = '{80,  12'h020,                 1'b1, 80,  79, 3'b100};
    tab[8] = '{5,   12'h001,                 1'b0, 6,   5,  3'b010};
    tab[9] = '{12,  12'h003,                 1'b0, 13,  12, 3'b010};

    // Reset held with pulso toggling.
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      ifa.pulso = ~ifa.pulso;
    end
    chk("rst medida",  32'(ifa.medida),    32'h000);
    chk("rst pronto",  32'(ifa.pronto),    32'h0);
    chk("rst timeout", 32'(ifa.timeout),   32'h0);
    chk("rst ocupado", 32'(ifa.ocupado),   32'h0);
    chk("rst estado",  32'(ifa.db_estado), 32'h0);
    ifa.pulso = 1'b0;
    rst_n     = 1'b1;
    #1;
    chk("rel estado0", 32'(ifa.db_estado), 32'h0);
    @(posedge clk); #1;
    chk("rel estado1", 32'(ifa.db_estado), 32'h1);

    for (int i = 0; i < 10; i++) begin
      chk($sformatf("v%0d pre estado", i), 32'(ifa.db_estado), 32'h1);
      measure(1'b0, tab[i].n, np, pat, mp, tp, oc, es);
      chk($sformatf("v%0d n pronto", i),   32'(np),  32'd1);
      chk($sformatf("v%0d pronto at", i),  32'(pat), 32'(tab[i].pronto_at));
      chk($sformatf("v%0d medida@p", i),   32'(mp),  32'(tab[i].med));
      chk($sformatf("v%0d timeout@p", i),  32'(tp),  32'(tab[i].tmo));
      chk($sformatf("v%0d ocupado cyc", i), 32'(oc), 32'(tab[i].ocup));
      chk($sformatf("v%0d estado@n", i),   32'(es),  32'(tab[i].est_n));
      chk($sformatf("v%0d medida hold", i),  32'(ifa.medida),  32'(tab[i].med));
      chk($sformatf("v%0d timeout hold", i), 32'(ifa.timeout), 32'(tab[i].tmo));
    end

    // Reset in the middle of a measurement.
    np = 0;
    ifa.pulso = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (ifa.pronto) np++;
    end
    chk("mid ocupado", 32'(ifa.ocupado), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid medida",  32'(ifa.medida),    32'h000);
    chk("mid pronto",  32'(ifa.pronto),    32'h0);
    chk("mid ocupado0", 32'(ifa.ocupado),  32'h0);
    chk("mid estado",  32'(ifa.db_estado), 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (ifa.pronto) np++;
      ifa.pulso = ~ifa.pulso;
    end
    chk("mid no pronto", 32'(np), 32'd0);
    ifa.pulso = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk); #1;
    chk("mid estado1", 32'(ifa.db_estado), 32'h1);
    measure(1'b0, 12, np, pat, mp, tp, oc, es);
    chk("post n pronto", 32'(np),  32'd1);
    chk("post pronto at", 32'(pat), 32'd13);
    chk("post medida",   32'(mp),  32'h003);

    // Full-scale instance: wrap and fall coincide at exactly 10 cm.
    chk("big pre estado", 32'(ifb.db_estado), 32'h1);
    measure(1'b1, 29410, np, pat, mp, tp, oc, es);
    chk("big n pronto",  32'(np),  32'd1);
    chk("big pronto at", 32'(pat), 32'd29411);
    chk("big medida",    32'(mp),  32'h010);
    chk("big timeout",   32'(tp),  32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
